stopwatch_ctrl: RTL and testbench

Control front end of the stopwatch: conditions the three push-buttons (start/stop, clear, lap), runs the RUN/PAUSE/IDLE state machine, and generates the 0.1 s count-enable and clear pulses. It sits directly upstream of the `timing` BCD counter. `en` drives `timing.en`, `clr` drives `timing.r`, and `hold` goes to the display latch that freezes the shown time for lap readings.

---
 rtl/stopwatch_pkg.sv | 24 ++
 rtl/btn_debounce.sv | 54 +++++
 rtl/stopwatch_ctrl.sv | 133 +++++++++++++
 tb/tb_stopwatch_ctrl.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/stopwatch_pkg.sv
// Shared types and defaults for the stopwatch control front end:
// FSM state encoding, button indices and counter width helper.
package stopwatch_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2
  } state_e;

  localparam int DEF_DEB_CYCLES = 1_000_000;
  localparam int DEF_TICK_DIV   = 10_000_000;

  localparam int BTN_SS   = 0;
  localparam int BTN_CLR  = 1;
  localparam int BTN_LAP  = 2;
  localparam int NUM_BTNS = 3;

  // Counter width for a modulus of n; never narrower than one bit.
  function automatic int cnt_width(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/btn_debounce.sv
// One push-button conditioner: 2-flop synchronizer, stable-level debouncer
// and a one-cycle pulse when the accepted level rises.
module btn_debounce
  import stopwatch_pkg::*;
#(
  parameter int DEB_CYCLES = DEF_DEB_CYCLES
) (
  input  logic clk,
  input  logic r_n,
  input  logic i_btn,
  output logic o_press
);

  localparam int             CW      = cnt_width(DEB_CYCLES);
  localparam logic [CW-1:0]  CNT_MAX = CW'(DEB_CYCLES - 1);

  logic          r_sync1;
  logic          r_sync2;
  logic          r_level;
  logic          r_press;
  logic [CW-1:0] r_cnt;

  logic w_diff;
  logic w_accept;

  assign w_diff   = r_sync2 ^ r_level;
  assign w_accept = w_diff && (r_cnt == CNT_MAX);

  always_ff @(posedge clk or negedge r_n) begin
    if (!r_n) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
      r_level <= 1'b0;
      r_press <= 1'b0;
      r_cnt   <= '0;
    end else begin
      r_sync1 <= i_btn;
      r_sync2 <= r_sync1;
      // Any cycle that agrees with the accepted level restarts the count.
      if (!w_diff) begin
        r_cnt <= '0;
      end else if (w_accept) begin
        r_cnt   <= '0;
        r_level <= r_sync2;
      end else begin
        r_cnt <= r_cnt + CW'(1);
      end
      r_press <= w_accept && r_sync2;
    end
  end

  assign o_press = r_press;

endmodule

// File: rtl/stopwatch_ctrl.sv
// Stopwatch control: button conditioning, IDLE/RUN/PAUSE FSM, 0.1 s tick
// prescaler and power-on clear for the downstream BCD counter.
module stopwatch_ctrl
  import stopwatch_pkg::*;
#(
  parameter int DEB_CYCLES = DEF_DEB_CYCLES,
  parameter int TICK_DIV   = DEF_TICK_DIV
) (
  input  logic clk,
  input  logic r_n,
  input  logic btn_ss,
  input  logic btn_clr,
  input  logic btn_lap,
  output logic en,
  output logic clr,
  output logic running,
  output logic hold
);

  localparam int            PW      = cnt_width(TICK_DIV);
  localparam logic [PW-1:0] PRE_MAX = PW'(TICK_DIV - 1);

  logic [NUM_BTNS-1:0] w_btn_raw;
  logic [NUM_BTNS-1:0] w_press;

  assign w_btn_raw = {btn_lap, btn_clr, btn_ss};

  generate
    for (genvar gi = 0; gi < NUM_BTNS; gi++) begin : g_btn
      btn_debounce #(
        .DEB_CYCLES(DEB_CYCLES)
      ) u_deb (
        .clk    (clk),
        .r_n    (r_n),
        .i_btn  (w_btn_raw[gi]),
        .o_press(w_press[gi])
      );
    end
  endgenerate

  state_e        r_state;
  state_e        w_state_next;
  logic [PW-1:0] r_presc;
  logic [PW-1:0] w_presc_next;
  logic          r_hold;
  logic          w_hold_next;
  logic          r_clr;
  logic          w_clr_next;
  logic          r_por;

  logic w_ss;
  logic w_clrp;
  logic w_lap;

  assign w_ss   = w_press[BTN_SS];
  assign w_clrp = w_press[BTN_CLR];
  assign w_lap  = w_press[BTN_LAP];

  // r_por is set by reset and drops on the first edge afterwards.
  always_ff @(posedge clk or negedge r_n) begin
    if (!r_n) begin
      r_state <= IDLE;
      r_presc <= '0;
      r_hold  <= 1'b0;
      r_clr   <= 1'b0;
      r_por   <= 1'b1;
    end else begin
      r_state <= w_state_next;
      r_presc <= w_presc_next;
      r_hold  <= w_hold_next;
      r_clr   <= w_clr_next;
      r_por   <= 1'b0;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_hold_next  = r_hold;
    w_clr_next   = r_por;
    unique case (r_state)
      IDLE: begin
        w_hold_next = 1'b0;
        if (w_clrp) begin
          w_clr_next = 1'b1;
        end else if (w_ss) begin
          w_state_next = RUN;
        end
      end
      RUN: begin
        if (w_clrp) begin
          w_state_next = IDLE;
          w_clr_next   = 1'b1;
          w_hold_next  = 1'b0;
        end else begin
          if (w_ss)  w_state_next = PAUSE;
          if (w_lap) w_hold_next  = ~r_hold;
        end
      end
      PAUSE: begin
        if (w_clrp) begin
          w_state_next = IDLE;
          w_clr_next   = 1'b1;
          w_hold_next  = 1'b0;
        end else begin
          if (w_ss)  w_state_next = RUN;
          if (w_lap) w_hold_next  = 1'b0;
        end
      end
      default: begin
        w_state_next = IDLE;
        w_hold_next  = 1'b0;
      end
    endcase

    // PAUSE keeps the partial interval so a resumed tick is not shortened.
    if (r_state == IDLE || w_state_next == IDLE) begin
      w_presc_next = '0;
    end else if (r_state == RUN) begin
      w_presc_next = (r_presc == PRE_MAX) ? '0 : r_presc + PW'(1);
    end else begin
      w_presc_next = r_presc;
    end
  end

  always_comb begin
    running = (r_state == RUN);
    en      = (r_state == RUN) && (r_presc == PRE_MAX);
  end

  assign hold = r_hold;
  assign clr  = r_clr;

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Directed bench for stopwatch_ctrl with DEB_CYCLES=4, TICK_DIV=10.
// A raw press at cycle 0 gives its pulse at cycle 6 and takes effect at cycle 7.
module tb_stopwatch_ctrl;

  logic clk     = 1'b0;
  logic r_n     = 1'b1;
  logic btn_ss  = 1'b0;
  logic btn_clr = 1'b0;
  logic btn_lap = 1'b0;
  logic en;
  logic clr;
  logic running;
  logic hold;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  stopwatch_ctrl #(
    .DEB_CYCLES(4),
    .TICK_DIV  (10)
  ) dut (
    .clk    (clk),
    .r_n    (r_n),
    .btn_ss (btn_ss),
    .btn_clr(btn_clr),
    .btn_lap(btn_lap),
    .en     (en),
    .clr    (clr),
    .running(running),
    .hold   (hold)
  );

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Raise one button (0=ss 1=clr 2=lap) at cycle 0 and stop at cycle 6.
  task automatic press(input int which);
    case (which)
      0: btn_ss  = 1'b1;
      1: btn_clr = 1'b1;
      default: btn_lap = 1'b1;
    endcase
    step(6);
  endtask

  task automatic release_all();
    btn_ss  = 1'b0;
    btn_clr = 1'b0;
    btn_lap = 1'b0;
    step(8);
  endtask

  task automatic test_reset();
    r_n = 1'b1;
    #2 r_n = 1'b0;
    #1;
    checks++; if ({en, clr, running, hold} !== 4'b0000) begin failures++; $display("FAIL reset_async outs got=%b exp=0000", {en, clr, running, hold}); end
    for (int i = 0; i < 3; i++) begin
      step(1);
      checks++; if ({en, clr, running, hold} !== 4'b0000) begin failures++; $display("FAIL reset_hold cyc=%0d outs got=%b exp=0000", i, {en, clr, running, hold}); end
    end
    r_n = 1'b1;
    step(1);
    checks++; if (clr !== 1'b1) begin failures++; $display("FAIL por_clr_high got=%b exp=1", clr); end
    checks++; if ({en, running, hold} !== 3'b000) begin failures++; $display("FAIL por_others got=%b exp=000", {en, running, hold}); end
    step(1);
    checks++; if (clr !== 1'b0) begin failures++; $display("FAIL por_clr_one_cycle got=%b exp=0", clr); end
    $display("test_reset done checks=%0d failures=%0d", checks, failures);
  endtask

  task automatic test_bounce();
    for (int i = 0; i < 30; i++) begin
      btn_ss = (i < 20) ? (((i / 2) % 2) == 0) : 1'b0;
      step(1);
      checks++; if ({en, clr, running} !== 3'b000) begin failures++; $display("FAIL bounce cyc=%0d en/clr/running got=%b exp=000", i, {en, clr, running}); end
    end
    $display("test_bounce done checks=%0d failures=%0d", checks, failures);
  endtask

  task automatic test_start();
    logic exp_en;
    btn_ss = 1'b1;
    for (int c = 1; c <= 40; c++) begin
      step(1);
      if (c == 8) btn_ss = 1'b0;
      exp_en = (c >= 16) && (((c - 16) % 10) == 0);
      checks++; if (running !== (c >= 7)) begin failures++; $display("FAIL start_running cyc=%0d got=%b exp=%b", c, running, (c >= 7)); end
      checks++; if (en !== exp_en) begin failures++; $display("FAIL start_en cyc=%0d got=%b exp=%b", c, en, exp_en); end
    end
    $display("test_start done checks=%0d failures=%0d", checks, failures);
  endtask

  task automatic test_pause_resume();
    bit found = 1'b0;
    for (int k = 0; k < 20 && !found; k++) begin
      step(1);
      if (en === 1'b1) found = 1'b1;
    end
    checks++; if (!found) begin failures++; $display("FAIL pause_wait_en got=timeout exp=en pulse within 20 cycles"); end
    // Raised in the en cycle (prescaler 9): pulse lands at prescaler 5, PAUSE holds 6.
    btn_ss = 1'b1;
    for (int c = 1; c <= 70; c++) begin
      step(1);
      if (c == 8) btn_ss = 1'b0;
      checks++; if (running !== (c <= 6)) begin failures++; $display("FAIL pause_running cyc=%0d got=%b exp=%b", c, running, (c <= 6)); end
      checks++; if (en !== 1'b0) begin failures++; $display("FAIL pause_en cyc=%0d got=%b exp=0", c, en); end
    end
    btn_ss = 1'b1;
    for (int c = 1; c <= 20; c++) begin
      step(1);
      if (c == 8) btn_ss = 1'b0;
      checks++; if (running !== (c >= 7)) begin failures++; $display("FAIL resume_running cyc=%0d got=%b exp=%b", c, running, (c >= 7)); end
      checks++; if (en !== (c == 10 || c == 20)) begin failures++; $display("FAIL resume_en cyc=%0d got=%b exp=%b", c, en, (c == 10 || c == 20)); end
    end
    $display("test_pause_resume done checks=%0d failures=%0d", checks, failures);
  endtask

  task automatic test_clr_priority();
    int clr_count = 0;
    btn_ss  = 1'b1;
    btn_clr = 1'b1;
    for (int c = 1; c <= 20; c++) begin
      step(1);
      if (c == 8) begin
        btn_ss  = 1'b0;
        btn_clr = 1'b0;
      end
      if (clr === 1'b1) clr_count++;
      checks++; if (running !== (c <= 6)) begin failures++; $display("FAIL clrpri_running cyc=%0d got=%b exp=%b", c, running, (c <= 6)); end
      if (c == 7) begin
        checks++; if (clr !== 1'b1) begin failures++; $display("FAIL clrpri_clr_pulse got=%b exp=1", clr); end
      end
    end
    checks++; if (clr_count != 1) begin failures++; $display("FAIL clrpri_clr_count got=%0d exp=1", clr_count); end
    // A fresh start from IDLE has prescaler 0, so the first en is in RUN cycle 10.
    btn_ss = 1'b1;
    for (int c = 1; c <= 20; c++) begin
      step(1);
      if (c == 8) btn_ss = 1'b0;
      checks++; if (en !== (c == 16)) begin failures++; $display("FAIL clrpri_restart_en cyc=%0d got=%b exp=%b", c, en, (c == 16)); end
    end
    $display("test_clr_priority done checks=%0d failures=%0d", checks, failures);
  endtask

  task automatic test_lap();
    press(2);
    checks++; if (hold !== 1'b0) begin failures++; $display("FAIL lap1_pre_hold got=%b exp=0", hold); end
    step(1);
    checks++; if (hold !== 1'b1) begin failures++; $display("FAIL lap1_hold got=%b exp=1", hold); end
    release_all();
    press(2); step(1);
    checks++; if (hold !== 1'b0) begin failures++; $display("FAIL lap2_hold got=%b exp=0", hold); end
    release_all();
    press(2); step(1);
    checks++; if (hold !== 1'b1) begin failures++; $display("FAIL lap3_hold got=%b exp=1", hold); end
    release_all();
    press(1); step(1);
    checks++; if ({clr, hold, running} !== 3'b100) begin failures++; $display("FAIL lap_clr clr/hold/running got=%b exp=100", {clr, hold, running}); end
    release_all();
    press(2); step(1);
    checks++; if (hold !== 1'b0) begin failures++; $display("FAIL lap_idle_ignored got=%b exp=0", hold); end
    release_all();
    press(0); step(1);
    checks++; if (running !== 1'b1) begin failures++; $display("FAIL lap_restart_running got=%b exp=1", running); end
    release_all();
    press(2); step(1);
    checks++; if (hold !== 1'b1) begin failures++; $display("FAIL lap_run_hold got=%b exp=1", hold); end
    release_all();
    press(0); step(1);
    checks++; if ({running, hold} !== 2'b01) begin failures++; $display("FAIL lap_pause_entry running/hold got=%b exp=01", {running, hold}); end
    release_all();
    press(2); step(1);
    checks++; if ({running, hold} !== 2'b00) begin failures++; $display("FAIL lap_pause_force running/hold got=%b exp=00", {running, hold}); end
    release_all();
    press(1); step(1);
    checks++; if (clr !== 1'b1) begin failures++; $display("FAIL lap_pause_clr got=%b exp=1", clr); end
    release_all();
    $display("test_lap done checks=%0d failures=%0d", checks, failures);
  endtask

  task automatic test_reset_mid();
    press(0); step(1); release_all();
    press(2); step(1); release_all();
    checks++; if ({running, hold} !== 2'b11) begin failures++; $display("FAIL mid_setup running/hold got=%b exp=11", {running, hold}); end
    btn_ss = 1'b1;
    #2 r_n = 1'b0;
    #1;
    checks++; if ({en, clr, running, hold} !== 4'b0000) begin failures++; $display("FAIL mid_async outs got=%b exp=0000", {en, clr, running, hold}); end
    for (int i = 0; i < 3; i++) begin
      step(1);
      checks++; if ({en, clr, running, hold} !== 4'b0000) begin failures++; $display("FAIL mid_hold cyc=%0d outs got=%b exp=0000", i, {en, clr, running, hold}); end
    end
    btn_ss = 1'b0;
    r_n    = 1'b1;
    step(1);
    checks++; if (clr !== 1'b1) begin failures++; $display("FAIL mid_por_clr got=%b exp=1", clr); end
    step(1);
    checks++; if ({clr, running, hold} !== 3'b000) begin failures++; $display("FAIL mid_after clr/running/hold got=%b exp=000", {clr, running, hold}); end
    $display("test_reset_mid done checks=%0d failures=%0d", checks, failures);
  endtask

  initial begin
    test_reset();
    test_bounce();
    test_start();
    test_pause_resume();
    test_clr_priority();
    test_lap();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
